result_packer: RTL

Packs successive 32-bit adder results into 64-bit memory words for the calculator datapath. It sits between the adder and the controller's write path. It takes one half-word per accepted beat, steered by the controller's buffer select (1 = upper, 0 = lower). Completed words go into a 2-entry output FIFO, which the controller drains on its memory write.

---
 rtl/result_packer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/result_packer.sv
// Packs two DATA_W adder results into one MEM_WORD_SIZE word and queues completed words in a 2-entry FIFO.
// Optional macro RESULT_PACKER_STATS_EN adds a saturating word_count_o push counter.
module result_packer #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [DATA_W-1:0]        sum_i,
    input  logic                     carry_i,
    input  logic                     sum_valid_i,
    output logic                     sum_ready_o,
    input  logic                     buffer_control_i,
    output logic [MEM_WORD_SIZE-1:0] word_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic                     overflow_o,
    output logic                     dup_err_o
`ifdef RESULT_PACKER_STATS_EN
    ,
    output logic [15:0]              word_count_o
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_LOWER = 2'b01,
        S_UPPER = 2'b10
    } state_t;

    state_t                     state_q, state_d;
    logic [DATA_W-1:0]          hi_q, lo_q, hi_d, lo_d;
    logic [MEM_WORD_SIZE-1:0]   push_word;
    logic [MEM_WORD_SIZE-1:0]   mem_q [2];
    logic                       wr_ptr_q, rd_ptr_q;
    logic [1:0]                 count_q;
    logic                       ovf_q, dup_q;
    logic                       accept, push, pop, dup;

    assign sum_ready_o  = (count_q != 2'd2);
    assign accept       = sum_valid_i && sum_ready_o;
    assign pop          = (count_q != 2'd0) && word_ready_i;
    assign push_word    = {hi_d, lo_d};

    // Assembly: the mask is the state, so a completing beat pushes the merged halves.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        push    = 1'b0;
        dup     = 1'b0;
        if (accept) begin
            if (buffer_control_i) hi_d = sum_i;
            else                  lo_d = sum_i;
            case (state_q)
                S_EMPTY: state_d = buffer_control_i ? S_UPPER : S_LOWER;
                S_LOWER: begin
                    if (buffer_control_i) begin
                        push    = 1'b1;
                        state_d = S_EMPTY;
                    end else begin
                        dup = 1'b1;
                    end
                end
                S_UPPER: begin
                    if (!buffer_control_i) begin
                        push    = 1'b1;
                        state_d = S_EMPTY;
                    end else begin
                        dup = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Control state: clear takes priority and drops any concurrent beat or pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q  <= S_EMPTY;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ovf_q    <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
            ovf_q   <= ovf_q | (accept & carry_i);
            dup_q   <= dup_q | dup;
        end
    end

    // Data path: stale contents after reset are harmless because the mask and count gate them.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
        if (push && rst_ni && !clear_i) mem_q[wr_ptr_q] <= push_word;
    end

    assign word_valid_o = (count_q != 2'd0);
    assign word_o       = word_valid_o ? mem_q[rd_ptr_q] : '0;
    assign overflow_o   = ovf_q;
    assign dup_err_o    = dup_q;

`ifdef RESULT_PACKER_STATS_EN
    logic [15:0] word_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) word_cnt_q <= 16'd0;
        else if (push)          word_cnt_q <= sat_inc16(word_cnt_q);
    end

    assign word_count_o = word_cnt_q;
`endif

endmodule
